// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared constants and pointer-encoding helpers for the async FIFO
// Contents: READ_STD/READ_FWFT read-mode selectors, clogb2, bin2gray, gray2bin.
package async_fifo_pkg;

    localparam int READ_STD  = 0;
    localparam int READ_FWFT = 1;

    function automatic int clogb2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary is the XOR of every right shift of the Gray word.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) b = b ^ (g >> i);
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_sdp_ram.sv
// async_fifo_sdp_ram: simple dual-port storage, write on wr_clk, registered read on rd_clk
// Ports: wr_clk/wr_en/wr_addr/wr_data write port; rd_clk/rd_rst_n/rd_en/rd_addr read port;
//        rd_data is the read register (cleared by rd_rst_n, array contents are never reset).
module async_fifo_sdp_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 8,
    parameter int AW    = 10
) (
    input  logic             wr_clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_clk,
    input  logic             rd_rst_n,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge wr_clk)
        if (wr_en) mem[wr_addr] <= wr_data;

    always_ff @(posedge rd_clk or negedge rd_rst_n)
        if (!rd_rst_n) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];

endmodule

// File: rtl/async_fifo_mode.sv
// async_fifo_mode: dual-clock FIFO with Gray-synchronised pointers, standard or FWFT read
// Write side (wr_clk_i, wr_rst_n_i async active-low): wr_en_i, din, full, prog_full, overflow, wr_fifo_num.
// Read side (rd_clk_i, rd_rst_n_i async active-low): rd_en_i, dout, valid, empty, prog_empty, underflow, rd_fifo_num.
module async_fifo_mode
    import async_fifo_pkg::*;
#(
    parameter  int FIFO_DEEP      = 1024,
    parameter  int DATA_WIDTH     = 8,
    parameter  int PROG_FULL_NUM  = 1000,
    parameter  int PROG_EMPTY_NUM = 4,
    parameter  int READ_MODE      = 0,
    parameter  int SYNC_STAGES    = 2,
    localparam int AW             = clogb2(FIFO_DEEP)
) (
    input  logic                  wr_clk_i,
    input  logic                  wr_rst_n_i,
    input  logic                  rd_clk_i,
    input  logic                  rd_rst_n_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  prog_full,
    output logic                  overflow,
    output logic [AW:0]           wr_fifo_num,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  empty,
    output logic                  prog_empty,
    output logic                  underflow,
    output logic [AW:0]           rd_fifo_num
);

    localparam int PW   = AW + 1;
    localparam bit FWFT = READ_MODE == READ_FWFT;

    logic [AW:0] wr_ptr, wr_ptr_nxt, wr_gray, rd_ptr_w, rd_ptr_w_nxt, wr_num_nxt;
    logic [AW:0] rd_ptr, rd_ptr_nxt, rd_gray, wr_ptr_r, wr_ptr_r_nxt, mem_num, rd_num_nxt;
    logic [AW:0] rd_sync [SYNC_STAGES];
    logic [AW:0] wr_sync [SYNC_STAGES];
    logic        wr_acc, fetch, valid_nxt;

    // The "next" synced pointer is the stage feeding the last flop, so the
    // registered flags always agree with the fill level shown the cycle after.
    assign wr_acc       = wr_en_i && !full;
    assign wr_ptr_nxt   = wr_ptr + PW'(wr_acc);
    assign rd_ptr_w     = PW'(gray2bin(32'(rd_sync[SYNC_STAGES-1])));
    assign rd_ptr_w_nxt = PW'(gray2bin(32'(rd_sync[SYNC_STAGES-2])));
    assign wr_num_nxt   = wr_ptr_nxt - rd_ptr_w_nxt;
    assign wr_fifo_num  = wr_ptr - rd_ptr_w;

    always_ff @(posedge wr_clk_i or negedge wr_rst_n_i)
        if (!wr_rst_n_i) begin
            wr_ptr    <= '0;
            wr_gray   <= '0;
            full      <= 1'b0;
            prog_full <= 1'b0;
            overflow  <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) rd_sync[i] <= '0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            wr_gray   <= PW'(bin2gray(32'(wr_ptr_nxt)));
            full      <= wr_num_nxt == PW'(FIFO_DEEP);
            prog_full <= wr_num_nxt >= PW'(PROG_FULL_NUM);
            overflow  <= wr_en_i && full;
            rd_sync[0] <= rd_gray;
            for (int i = 1; i < SYNC_STAGES; i++) rd_sync[i] <= rd_sync[i-1];
        end

    // FWFT keeps the RAM read register loaded with the head word whenever it
    // is free or being popped; standard mode fetches only on request. The
    // word held in the read register is counted in rd_fifo_num.
    assign wr_ptr_r     = PW'(gray2bin(32'(wr_sync[SYNC_STAGES-1])));
    assign wr_ptr_r_nxt = PW'(gray2bin(32'(wr_sync[SYNC_STAGES-2])));
    assign mem_num      = wr_ptr_r - rd_ptr;
    assign fetch        = FWFT ? (mem_num != '0) && (!valid || rd_en_i) : rd_en_i && !empty;
    assign valid_nxt    = FWFT ? fetch || (valid && !rd_en_i) : fetch;
    assign rd_ptr_nxt   = rd_ptr + PW'(fetch);
    assign rd_num_nxt   = wr_ptr_r_nxt - rd_ptr_nxt + PW'(FWFT && valid_nxt);
    assign rd_fifo_num  = mem_num + PW'(FWFT && valid);

    always_ff @(posedge rd_clk_i or negedge rd_rst_n_i)
        if (!rd_rst_n_i) begin
            rd_ptr     <= '0;
            rd_gray    <= '0;
            valid      <= 1'b0;
            empty      <= 1'b1;
            prog_empty <= 1'b1;
            underflow  <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) wr_sync[i] <= '0;
        end else begin
            rd_ptr     <= rd_ptr_nxt;
            rd_gray    <= PW'(bin2gray(32'(rd_ptr_nxt)));
            valid      <= valid_nxt;
            empty      <= FWFT ? !valid_nxt : rd_num_nxt == '0;
            prog_empty <= rd_num_nxt <= PW'(PROG_EMPTY_NUM);
            underflow  <= rd_en_i && empty;
            wr_sync[0] <= wr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) wr_sync[i] <= wr_sync[i-1];
        end

    async_fifo_sdp_ram #(
        .DEPTH(FIFO_DEEP),
        .WIDTH(DATA_WIDTH),
        .AW   (AW)
    ) u_ram (
        .wr_clk  (wr_clk_i),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (din),
        .rd_clk  (rd_clk_i),
        .rd_rst_n(rd_rst_n_i),
        .rd_en   (fetch),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (dout)
    );

endmodule

// File: doc/async_fifo_mode.md
ASYNC_FIFO_MODE -- requirements
Module: async_fifo_mode

Interface
REQ-001 The block SHALL have the following parameters:
- FIFO_DEEP, default 1024: word capacity; power of two, at least 16.
- DATA_WIDTH, default 8: word width.
- PROG_FULL_NUM, default 1000: prog_full threshold, in words.
- PROG_EMPTY_NUM, default 4: prog_empty threshold, in words.
- READ_MODE, default 0: 0 = standard read, 1 = first-word-fall-through (FWFT).
- SYNC_STAGES, default 2: flops per pointer synchroniser, range 2..4.
REQ-002 The block SHALL have the following ports, with AW = log2(FIFO_DEEP):
- wr_clk_i  in  1  write clock.
- wr_rst_n_i  in  1  write-domain reset.
- rd_clk_i  in  1  read clock.
- rd_rst_n_i  in  1  read-domain reset, asynchronous, active-low.
- wr_en_i  in  1  write request.
- din  in  DATA_WIDTH  write data.
- full  out  1  no space.
- prog_full  out  1  fill level at or above PROG_FULL_NUM.
- overflow  out  1  write rejected.
- wr_fifo_num  out  AW+1  fill level seen from the write side.
- rd_en_i  in  1  read request.
- dout  out  DATA_WIDTH  read data.
- valid  out  1  dout qualifier.
- empty  out  1  no data.
- prog_empty  out  1  fill level at or below PROG_EMPTY_NUM.
- underflow  out  1  read rejected.
- rd_fifo_num  out  AW+1  fill level seen from the read side.
REQ-003 Reset wr_rst_n_i SHALL be asynchronous and active-low; clock wr_clk_i.

Function
REQ-004 Pointers SHALL be AW+1-bit binary counters; the MSB is the wrap bit; addresses are the low AW bits.
REQ-005 Each pointer SHALL cross domains as Gray code through a SYNC_STAGES flop chain and SHALL be converted back to binary in the receiving domain.
REQ-006 wr_fifo_num SHALL equal wr_ptr minus synced rd_ptr; rd_fifo_num SHALL equal synced wr_ptr minus rd_ptr; both are modulo 2^(AW+1).
REQ-007 A write SHALL be accepted when wr_en_i=1 and full=0; the word is stored at wr_addr and wr_ptr increments on the same edge.
REQ-008 When wr_en_i=1 and full=1, no state SHALL change and overflow SHALL be 1 on the next cycle, for one cycle per rejected write.
REQ-009 full SHALL be registered and SHALL be 1 in the cycle after the write that makes wr_fifo_num reach FIFO_DEEP.
REQ-010 prog_full SHALL be registered and SHALL equal (next wr_fifo_num >= PROG_FULL_NUM).
REQ-011 Standard mode (READ_MODE=0): a read SHALL be accepted when rd_en_i=1 and empty=0; dout and valid=1 appear one rd_clk later; valid is 0 otherwise.
REQ-012 FWFT mode (READ_MODE=1): the head word SHALL be presented on dout with valid=1 and empty=0 without a request; rd_en_i with valid=1 pops it, and the next word (if any) is shown on the following cycle, so back-to-back reads run at 1 word/clk.
REQ-013 In FWFT mode, a word written into an empty FIFO SHALL reach dout/valid no later than SYNC_STAGES+3 rd_clk edges after the write edge; rd_fifo_num SHALL include the word held in the output register.
REQ-014 When rd_en_i=1 and empty=1, no state SHALL change and underflow SHALL be 1 for one cycle.
REQ-015 empty and prog_empty SHALL be registered; prog_empty SHALL equal (next rd_fifo_num <= PROG_EMPTY_NUM).
REQ-016 A simultaneous write and read SHALL both be serviced in their own domains, with no data loss at any fill level.
REQ-017 Pointer wrap from 2^(AW+1)-1 to 0 SHALL be seamless, with no flag glitch.
REQ-018 Flags SHALL be pessimistic: full and empty deassert only after synchroniser latency, and never assert late.

Reset
REQ-019 Write-domain reset SHALL clear wr_ptr and the rd-pointer synchroniser; full=0, prog_full=0, overflow=0, wr_fifo_num=0.
REQ-020 Read-domain reset SHALL clear rd_ptr, the wr-pointer synchroniser and the output register; empty=1, prog_empty=1, valid=0, dout=0, underflow=0, rd_fifo_num=0.
REQ-021 Both resets SHALL be asserted with overlapping pulses; a single-domain reset mid-operation is unsupported, and the FIFO returns to empty only after both are released.
REQ-022 RAM contents SHALL NOT be reset.

Structure
REQ-023 Package async_fifo_pkg SHALL hold clogb2, bin2gray and gray2bin functions and the READ_STD/READ_FWFT constants.
REQ-024 Storage SHALL be one sub-module, async_fifo_sdp_ram: simple dual-port RAM, write on wr_clk, registered read on rd_clk, depth FIFO_DEEP, width DATA_WIDTH.

Verification
REQ-025 FIFO_DEEP=16, standard mode: write 0x00..0x0F -> full=1 after the 16th write; a 17th write gives overflow for one cycle; reading 16 words returns 0x00..0x0F, each valid one clock after rd_en_i.
REQ-026 FWFT mode, wr_clk 100 MHz / rd_clk 37 MHz: a single write of 0xA5 -> dout=0xA5 with valid=1 within 5 rd_clk edges, and empty=0 without rd_en_i.
REQ-027 Read on empty in either mode -> underflow=1 for one cycle; rd_ptr and rd_fifo_num unchanged.
REQ-028 Random concurrent traffic of 10,000 words with both clock ratios swapped -> output sequence identical to input; no overflow or underflow when requests are gated by full/empty.
REQ-029 PROG_FULL_NUM=12, PROG_EMPTY_NUM=3 -> prog_full asserts at fill level 12, and prog_empty deasserts at fill level 4 as seen from the read side.
REQ-030 Assert both resets while half full -> flags return to reset values, and a subsequent write/read of 0x3C returns 0x3C.
